// File: rtl/arp_tx_builder_pkg.sv
// Shared ARP constants, field bundle and byte-select helper
// for the ARP transmit builder.
package arp_tx_builder_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN       = 8'h06;
  localparam logic [7:0]  ARP_PLEN       = 8'h04;
  localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
  localparam logic [15:0] ARP_OPER_REP   = 16'h0002;
  localparam int          ARP_OFS_SPA    = 14;
  localparam int          ARP_OFS_TPA    = 24;
  localparam int          ARP_BODY_LEN   = 28;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic        oper_reply;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } arp_fields_t;

  // Body is packed MSB-first so byte idx is the top byte after a left shift.
  function automatic logic [7:0] arp_byte(
    input logic [5:0]  idx,
    input arp_fields_t f
  );
    logic [223:0] body;
    logic [223:0] sh;
    body = {ARP_HTYPE_ETH, ARP_PTYPE_IPV4, ARP_HLEN, ARP_PLEN,
            (f.oper_reply ? ARP_OPER_REP : ARP_OPER_REQ),
            f.sha, f.spa, f.tha, f.tpa};
    sh = body << {idx, 3'b000};
    if (idx >= 6'(ARP_BODY_LEN)) return 8'h00;
    return sh[223:216];
  endfunction

endpackage

// File: rtl/arp_tx_builder.sv
// ARP packet body serialiser: latches MAC/IP fields on start
// and streams HTYPE..TPA plus zero pad with valid/ready handshake.
import arp_tx_builder_pkg::*;

module arp_tx_builder #(
  parameter int PAYLOAD_LEN = 46
) (
  input  logic        clock,
  input  logic        aclr_n,
  input  logic        start,
  input  logic        oper_reply,
  input  logic [47:0] sha,
  input  logic [31:0] spa,
  input  logic [47:0] tha,
  input  logic [31:0] tpa,
  input  logic        tx_ready,
  output logic [7:0]  data,
  output logic        data_en,
  output logic        busy,
  output logic        done
);

  localparam logic [5:0] LAST = 6'(PAYLOAD_LEN - 1);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  arp_fields_t fld_q, fld_d;
  logic [7:0]  data_q, data_d;
  logic        data_en_q, data_en_d;
  logic        done_q, done_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fld_d     = fld_q;
    data_d    = data_q;
    data_en_d = data_en_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          fld_d.oper_reply = oper_reply;
          fld_d.sha        = sha;
          fld_d.spa        = spa;
          fld_d.tha        = oper_reply ? tha : 48'h0;
          fld_d.tpa        = tpa;
          cnt_d            = 6'd0;
          data_d           = arp_byte(6'd0, fld_d);
          data_en_d        = 1'b1;
          state_d          = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (cnt_q == LAST) begin
            data_d    = 8'h00;
            data_en_d = 1'b0;
            done_d    = 1'b1;
            state_d   = ST_DONE;
          end else begin
            cnt_d  = cnt_q + 6'd1;
            data_d = arp_byte(cnt_d, fld_q);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d   = ST_IDLE;
        data_d    = 8'h00;
        data_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 6'd0;
      fld_q     <= '0;
      data_q    <= 8'h00;
      data_en_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fld_q     <= fld_d;
      data_q    <= data_d;
      data_en_q <= data_en_d;
      done_q    <= done_d;
    end
  end

  assign data    = data_q;
  assign data_en = data_en_q;
  assign done    = done_q;
  assign busy    = (state_q == ST_SEND);

endmodule

// File: tb/tb_arp_tx_builder.sv
// Scoreboard bench for arp_tx_builder: a byte-list model is queued on
// each accepted start and a negedge monitor checks the stream.
module tb_arp_tx_builder;

  logic        clock = 1'b0;
  logic        aclr_n = 1'b0;
  logic        start = 1'b0;
  logic        oper_reply = 1'b0;
  logic [47:0] sha = '0;
  logic [31:0] spa = '0;
  logic [47:0] tha = '0;
  logic [31:0] tpa = '0;
  logic        tx_ready = 1'b0;
  logic [7:0]  data;
  logic        data_en;
  logic        busy;
  logic        done;

  arp_tx_builder #(.PAYLOAD_LEN(46)) dut (
    .clock(clock), .aclr_n(aclr_n), .start(start),
    .oper_reply(oper_reply), .sha(sha), .spa(spa),
    .tha(tha), .tpa(tpa), .tx_ready(tx_ready),
    .data(data), .data_en(data_en), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  logic [7:0] q[$];
  bit  done_exp = 1'b0;
  bit  last_pop;
  bit  mon_on = 1'b0;
  int  n_vec = 0;
  int  n_err = 0;

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endfunction

  // Expected packet: fields in network order, then zero pad to 46.
  function automatic void model_push(bit rep, logic [47:0] s_ha,
                                     logic [31:0] s_pa,
                                     logic [47:0] t_ha,
                                     logic [31:0] t_pa);
    logic [47:0] th;
    th = rep ? t_ha : 48'h0;
    q.push_back(8'h00); q.push_back(8'h01);
    q.push_back(8'h08); q.push_back(8'h00);
    q.push_back(8'h06); q.push_back(8'h04);
    q.push_back(8'h00); q.push_back(rep ? 8'h02 : 8'h01);
    for (int i = 5; i >= 0; i--) q.push_back(s_ha[8*i +: 8]);
    for (int i = 3; i >= 0; i--) q.push_back(s_pa[8*i +: 8]);
    for (int i = 5; i >= 0; i--) q.push_back(th[8*i +: 8]);
    for (int i = 3; i >= 0; i--) q.push_back(t_pa[8*i +: 8]);
    while (q.size() < 46) q.push_back(8'h00);
  endfunction

  always @(negedge clock) begin
    if (aclr_n && mon_on) begin
      last_pop = 1'b0;
      chk("done", done, done_exp);
      chk("busy", busy, q.size() != 0);
      if (data_en) begin
        if (q.size() == 0) begin
          chk("spurious_byte", data_en, 0);
        end else begin
          chk("data", data, q[0]);
          if (tx_ready) begin
            void'(q.pop_front());
            last_pop = (q.size() == 0);
          end
        end
      end else begin
        chk("idle_data", data, 0);
      end
      done_exp = last_pop;
    end
  end

  task automatic go(bit rep, logic [47:0] s_ha, logic [31:0] s_pa,
                    logic [47:0] t_ha, logic [31:0] t_pa);
    @(posedge clock); #1;
    oper_reply = rep; sha = s_ha; spa = s_pa; tha = t_ha; tpa = t_pa;
    start = 1'b1;
    @(posedge clock);
    model_push(rep, s_ha, s_pa, t_ha, t_pa);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(bit rnd);
    int cyc;
    cyc = 0;
    while (done !== 1'b1) begin
      @(posedge clock); #1;
      if (rnd) tx_ready = ($urandom_range(0, 3) != 0);
      cyc++;
      if (cyc > 400) begin
        chk("timeout_done", 0, 1);
        q.delete();
        return;
      end
    end
  endtask

  localparam logic [47:0] SHA1 = 48'h020000000001;
  localparam logic [31:0] SPA1 = 32'hC0A80A02;
  localparam logic [47:0] THA1 = 48'h001122334455;
  localparam logic [31:0] TPA1 = 32'hC0A80A01;

  initial begin
    logic        r_rep;
    logic [47:0] r_sha, r_tha;
    logic [31:0] r_spa, r_tpa;
    #12;
    chk("rst_data", data, 0);
    chk("rst_data_en", data_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #5 aclr_n = 1'b1;
    mon_on = 1'b1;
    tx_ready = 1'b1;

    go(1'b1, SHA1, SPA1, THA1, TPA1);
    wait_done(1'b0);
    repeat (2) @(posedge clock);

    go(1'b0, SHA1, SPA1, 48'hFFFFFFFFFFFF, TPA1);
    wait_done(1'b0);
    // In DONE now: start here is ignored, the next one is accepted.
    r_sha = {$urandom, $urandom};
    r_spa = $urandom;
    r_tha = {$urandom, $urandom};
    r_tpa = $urandom;
    oper_reply = 1'b1; sha = r_sha; spa = r_spa;
    tha = r_tha; tpa = r_tpa;
    start = 1'b1;
    @(posedge clock); #1;
    @(posedge clock);
    model_push(1'b1, r_sha, r_spa, r_tha, r_tpa);
    #1 start = 1'b0;
    wait_done(1'b1);

    tx_ready = 1'b1;
    go(1'b1, SHA1, SPA1, THA1, TPA1);
    repeat (14) @(posedge clock);
    #1 tx_ready = 1'b0;
    repeat (5) @(posedge clock);
    #1 tx_ready = 1'b1;
    wait_done(1'b0);

    go(1'b1, SHA1, SPA1, THA1, TPA1);
    repeat (20) @(posedge clock);
    #1 spa = 32'h0A000001;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(1'b0);
    repeat (5) @(posedge clock);

    go(1'b1, SHA1, SPA1, THA1, TPA1);
    repeat (10) @(posedge clock);
    #3 aclr_n = 1'b0;
    mon_on = 1'b0;
    #1;
    chk("mid_rst_data", data, 0);
    chk("mid_rst_data_en", data_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    q.delete();
    done_exp = 1'b0;
    @(posedge clock);
    #3 aclr_n = 1'b1;
    mon_on = 1'b1;
    go(1'b1, SHA1, SPA1, THA1, TPA1);
    wait_done(1'b0);

    for (int k = 0; k < 8; k++) begin
      r_rep = 1'($urandom_range(0, 1));
      r_sha = {$urandom, $urandom};
      r_spa = $urandom;
      r_tha = {$urandom, $urandom};
      r_tpa = $urandom;
      go(r_rep, r_sha, r_spa, r_tha, r_tpa);
      wait_done(1'b1);
    end

    repeat (4) @(posedge clock);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
